systolic_operand_feeder: RTL and testbench

//  Upstream stage of the SIZE x SIZE systolic matrix-multiply array.
//  - Buffers matrix A (row by row) and matrix B (column by column) through a write port.
//  - On a go pulse, streams the operands into the array as diagonally skewed lane words.
//  - Drives the array's a/b operand lines, START and N for one complete multiply.

---
 rtl/systolic_operand_feeder.sv | 175 +++++++++++++++++
 tb/tb_systolic_operand_feeder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/systolic_operand_feeder.sv
// Operand feeder for the SIZE x SIZE systolic multiply array: buffers A rows / B columns
// and streams them as diagonally skewed lane words, one lane-selector instance per lane.

module systolic_feeder_lane #(
  parameter int DW    = 32,
  parameter int SIZE  = 6,
  parameter int IDX_W = 4,
  parameter int LANE  = 0
) (
  input  logic [SIZE*DW-1:0] line_i,
  input  logic [IDX_W:0]     t_i,
  input  logic [IDX_W-1:0]   n_i,
  output logic [DW-1:0]      word_o
);
  // Lane LANE carries element (t - LANE) of its stored line; anything outside the NxN window is 0.
  always_comb begin
    word_o = '0;
    if (n_i > IDX_W'(LANE)) begin
      for (int j = 0; j < SIZE; j++) begin
        if (n_i > IDX_W'(j) && t_i == (IDX_W+1)'(LANE + j))
          word_o = line_i[(SIZE-j)*DW-1 -: DW];
      end
    end
  end
endmodule

module systolic_operand_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int SIZE       = 6,
  parameter int IDX_W      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic                       wr_mat,
  input  logic [IDX_W-1:0]           wr_idx,
  input  logic [SIZE*DATA_WIDTH-1:0] wr_line,
  input  logic                       go,
  input  logic [IDX_W-1:0]           n_in,
  output logic [SIZE*DATA_WIDTH-1:0] a_line,
  output logic [SIZE*DATA_WIDTH-1:0] b_line,
  output logic                       start_out,
  output logic [IDX_W-1:0]           n_out,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);
  localparam int LW = SIZE*DATA_WIDTH;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [IDX_W:0]         t_q, t_d, t_nxt, t_last, d_last;
  logic [IDX_W-1:0]       n_q, n_d, n_nxt;
  logic [SIZE-1:0][LW-1:0] a_mem_q, a_mem_d, b_mem_q, b_mem_d;
  logic [LW-1:0]          a_q, a_d, b_q, b_d, a_pat, b_pat;
  logic                   start_q, start_d, done_q, done_d, err_q, err_d;
  logic                   idle, wr_en, go_ok, load;

  assign idle   = (state_q == S_IDLE);
  assign wr_en  = wr_valid & idle;
  assign go_ok  = go & idle & (n_in != '0) & (n_in <= IDX_W'(SIZE));
  assign t_last = {n_q, 1'b0} - (IDX_W+1)'(2);
  assign d_last = {1'b0, n_q} - (IDX_W+1)'(1);

  // Lanes read the post-write memory so a write in the go cycle feeds the first pattern.
  always_comb begin
    a_mem_d = a_mem_q;
    b_mem_d = b_mem_q;
    for (int r = 0; r < SIZE; r++) begin
      if (wr_en && wr_idx == IDX_W'(r)) begin
        if (wr_mat) b_mem_d[r] = wr_line;
        else        a_mem_d[r] = wr_line;
      end
    end
  end

  for (genvar k = 0; k < SIZE; k++) begin : g_lane
    systolic_feeder_lane #(.DW(DATA_WIDTH), .SIZE(SIZE), .IDX_W(IDX_W), .LANE(k)) u_a (
      .line_i(a_mem_d[k]), .t_i(t_nxt), .n_i(n_nxt),
      .word_o(a_pat[(SIZE-k)*DATA_WIDTH-1 -: DATA_WIDTH]));
    systolic_feeder_lane #(.DW(DATA_WIDTH), .SIZE(SIZE), .IDX_W(IDX_W), .LANE(k)) u_b (
      .line_i(b_mem_d[k]), .t_i(t_nxt), .n_i(n_nxt),
      .word_o(b_pat[(SIZE-k)*DATA_WIDTH-1 -: DATA_WIDTH]));
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    n_d     = n_q;
    start_d = start_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    load    = 1'b0;
    t_nxt   = t_q + (IDX_W+1)'(1);
    n_nxt   = n_q;
    case (state_q)
      S_IDLE: begin
        if (go_ok) begin
          state_d = S_STREAM;
          t_d     = '0;
          n_d     = n_in;
          start_d = 1'b1;
          load    = 1'b1;
          t_nxt   = '0;
          n_nxt   = n_in;
        end else if (go) begin
          err_d = 1'b1;
        end
      end
      S_STREAM: begin
        if (t_q == t_last) begin
          state_d = S_DRAIN;
          t_d     = '0;
        end else begin
          t_d  = t_q + (IDX_W+1)'(1);
          load = 1'b1;
        end
      end
      S_DRAIN: begin
        if (t_q == d_last) begin
          state_d = S_IDLE;
          t_d     = '0;
          start_d = 1'b0;
          done_d  = 1'b1;
        end else begin
          t_d = t_q + (IDX_W+1)'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        start_d = 1'b0;
      end
    endcase
    a_d = load ? a_pat : '0;
    b_d = load ? b_pat : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      n_q     <= '0;
      a_mem_q <= '0;
      b_mem_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      n_q     <= n_d;
      a_mem_q <= a_mem_d;
      b_mem_q <= b_mem_d;
      a_q     <= a_d;
      b_q     <= b_d;
      start_q <= start_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign wr_ready  = idle & rst;
  assign a_line    = a_q;
  assign b_line    = b_q;
  assign start_out = start_q;
  assign n_out     = n_q;
  assign busy      = ~idle;
  assign done      = done_q;
  assign err       = err_q;
endmodule

// File: tb/tb_systolic_operand_feeder.sv
// Scoreboard bench: expected per-cycle lane words come from a matrix model of A/B and the
// skew rule; a negedge monitor pops and compares whenever start_out is high.

module tb_systolic_operand_feeder;
  localparam int DW = 32, SIZE = 6, IDX_W = 4, LW = SIZE*DW;

  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;

  logic             wr_valid = 0, wr_mat = 0, go = 0;
  logic [IDX_W-1:0] wr_idx = 0, n_in = 0;
  logic [LW-1:0]    wr_line = '0;
  logic             wr_ready, start_out, busy, done, err;
  logic [LW-1:0]    a_line, b_line;
  logic [IDX_W-1:0] n_out;

  systolic_operand_feeder #(.DATA_WIDTH(DW), .SIZE(SIZE), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_mat(wr_mat),
    .wr_idx(wr_idx), .wr_line(wr_line), .go(go), .n_in(n_in), .a_line(a_line),
    .b_line(b_line), .start_out(start_out), .n_out(n_out), .busy(busy), .done(done), .err(err));

  typedef struct {logic [LW-1:0] a; logic [LW-1:0] b; logic [IDX_W-1:0] n;} exp_t;
  exp_t q[$];
  logic [DW-1:0] am[SIZE][SIZE];  // am[row][j]  = A[row][j]
  logic [DW-1:0] bm[SIZE][SIZE];  // bm[col][j]  = B[j][col]
  int n_pass = 0, n_tot = 0;

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic void model_clear();
    for (int r = 0; r < SIZE; r++)
      for (int j = 0; j < SIZE; j++) begin am[r][j] = '0; bm[r][j] = '0; end
  endfunction

  function automatic void model_wr(input logic mat, input int idx, input logic [LW-1:0] line);
    if (idx < SIZE)
      for (int j = 0; j < SIZE; j++)
        if (mat) bm[idx][j] = line[(SIZE-j)*DW-1 -: DW];
        else     am[idx][j] = line[(SIZE-j)*DW-1 -: DW];
  endfunction

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] l;
    for (int j = 0; j < SIZE; j++) l[(SIZE-j)*DW-1 -: DW] = $urandom | 32'h1;
    return l;
  endfunction

  // Whole run: 2N-1 skewed stream cycles then N zero drain cycles.
  function automatic void push_exp(input int n);
    exp_t e;
    for (int t = 0; t < 2*n-1; t++) begin
      e.a = '0; e.b = '0; e.n = IDX_W'(n);
      for (int k = 0; k < n; k++)
        if (t-k >= 0 && t-k < n) begin
          e.a[(SIZE-k)*DW-1 -: DW] = am[k][t-k];
          e.b[(SIZE-k)*DW-1 -: DW] = bm[k][t-k];
        end
      q.push_back(e);
    end
    for (int d = 0; d < n; d++) begin
      e.a = '0; e.b = '0; e.n = IDX_W'(n);
      q.push_back(e);
    end
  endfunction

  task automatic wr(input logic mat, input int idx, input logic [LW-1:0] line);
    wr_valid = 1; wr_mat = mat; wr_idx = IDX_W'(idx); wr_line = line;
    model_wr(mat, idx, line);
    tick();
    wr_valid = 0;
  endtask

  task automatic go_issue(input int n, input bit do_wr, input logic mat, input int idx,
                          input logic [LW-1:0] line);
    bit ok;
    ok = (n >= 1 && n <= SIZE);
    if (do_wr) begin
      wr_valid = 1; wr_mat = mat; wr_idx = IDX_W'(idx); wr_line = line;
      model_wr(mat, idx, line);
    end
    go = 1; n_in = IDX_W'(n);
    if (ok) push_exp(n);
    tick();
    go = 0; wr_valid = 0;
    if (!ok) begin
      chk("err_pulse", err, 1);
      chk("err_busy", busy, 0);
      tick();
      chk("err_clear", err, 0);
    end else begin
      chk("n_out_latch", n_out, n);
    end
  endtask

  task automatic wait_run(input int n, input int pre);
    int cnt;
    cnt = pre;
    while (busy && cnt < 200) begin cnt++; tick(); end
    chk("busy_cycles", cnt, 3*n-1);
    chk("done_pulse", done, 1);
    tick();
    chk("done_clear", done, 0);
    chk("queue_drained", q.size(), 0);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (start_out) begin
          if (q.size() == 0) begin
            n_tot++;
            $display("FAIL unexpected_start: got start_out=1 expected no activity");
          end else begin
            e = q.pop_front();
            chk("a_line", a_line, e.a);
            chk("b_line", b_line, e.b);
            chk("n_out", n_out, e.n);
          end
        end else begin
          chk("idle_a_zero", a_line, '0);
          chk("idle_b_zero", b_line, '0);
        end
        chk("busy_eq_start", busy, start_out);
      end
    end
  end

  initial begin
    logic [LW-1:0] l;
    int n;
    model_clear();
    #1;
    chk("rst_a", a_line, '0);
    chk("rst_busy", busy, 0);
    chk("rst_start", start_out, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_done_err", {done, err}, 0);
    #2 rst = 1;
    tick();
    chk("wr_ready_idle", wr_ready, 1);

    // 1: small worked example, N=2
    l = '0; l[LW-1 -: DW] = 1; l[LW-DW-1 -: DW] = 2; wr(0, 0, l);
    l = '0; l[LW-1 -: DW] = 3; l[LW-DW-1 -: DW] = 4; wr(0, 1, l);
    l = '0; l[LW-1 -: DW] = 5; l[LW-DW-1 -: DW] = 7; wr(1, 0, l);
    l = '0; l[LW-1 -: DW] = 6; l[LW-DW-1 -: DW] = 8; wr(1, 1, l);
    go_issue(2, 0, 0, 0, '0);
    wait_run(2, 0);

    // 2: full-size run with all memory nonzero
    for (int r = 0; r < SIZE; r++) begin wr(0, r, rnd_line()); wr(1, r, rnd_line()); end
    go_issue(6, 0, 0, 0, '0);
    wait_run(6, 0);

    // 3: rejected go values
    go_issue(0, 0, 0, 0, '0);
    go_issue(7, 0, 0, 0, '0);

    // 4: write and go while streaming are ignored; rerun shows memory unchanged
    go_issue(3, 0, 0, 0, '0);
    tick();
    wr_valid = 1; wr_mat = 0; wr_idx = 0; wr_line = rnd_line(); go = 1; n_in = 2;
    chk("wr_ready_busy", wr_ready, 0);
    tick();
    wr_valid = 0; go = 0;
    wait_run(3, 2);
    go_issue(3, 0, 0, 0, '0);
    wait_run(3, 0);

    // 5: async reset mid-run clears outputs and memories
    go_issue(4, 0, 0, 0, '0);
    tick(); tick();
    rst = 0; q.delete(); model_clear();
    #1;
    chk("midrst_a", a_line, '0);
    chk("midrst_b", b_line, '0);
    chk("midrst_start", start_out, 0);
    chk("midrst_busy", busy, 0);
    #2 rst = 1;
    tick();
    chk("midrst_no_done", done, 0);
    go_issue(4, 0, 0, 0, '0);
    wait_run(4, 0);

    // 6: full load, out-of-range index dropped, N=3 keeps upper lanes zero
    for (int r = 0; r < SIZE; r++) begin wr(0, r, rnd_line()); wr(1, r, rnd_line()); end
    wr(0, 6, rnd_line());
    wr(1, 6, rnd_line());
    go_issue(3, 0, 0, 0, '0);
    wait_run(3, 0);

    // Random mix, including write in the same cycle as go
    for (int it = 0; it < 12; it++) begin
      for (int w = 0; w < int'($urandom_range(0, 3)); w++)
        wr(1'($urandom_range(0, 1)), $urandom_range(0, 7), rnd_line());
      n = $urandom_range(0, 7);
      go_issue(n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom_range(0, SIZE-1), rnd_line());
      if (n >= 1 && n <= SIZE) wait_run(n, 0);
    end

    tick();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
